cmb_rotator_ctrl: RTL and testbench

Front-panel controller for the CMB rotator/stepper bench board, running from the 50 MHz board clock. It turns push-button and switch inputs into a free-running rotator clock, a gated stepper clock and an ADC trigger. It also keeps a 0..999 step position counter, drives a one-hot RF switch select, and shows the position and RF channel on LEDs and a 4-digit multiplexed 7-segment display.

---
 rtl/cmb_rotator_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cmb_rotator_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmb_rotator_ctrl.sv
// Front-panel controller for the CMB rotator/stepper bench: rotator clock divider,
// gated stepper clock, step position counter, RF switch select and 7-segment display.
module cmb_rotator_ctrl #(
    parameter int unsigned ROT_DIV   = 25,
    parameter int unsigned STEPS_REV = 1000,
    parameter int unsigned SCAN_DIV  = 16
) (
    input  logic       clk50,
    input  logic [3:0] pb,
    input  logic [7:0] sw,
    output logic       debug,
    output logic       rot_clk,
    output logic       adc_trg,
    output logic       stp_clk,
    output logic [3:0] digit,
    output logic [3:0] rf_sw,
    output logic [7:0] led,
    output logic [7:0] seg,
    output logic [9:0] rot_count
);
    localparam int unsigned DIV_W  = (ROT_DIV  > 1) ? $clog2(ROT_DIV)  : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic              rst_n;
    logic [2:0]        sync1, sync2, sync3, btn_pulse;
    logic              home_p, step_p, run_p;
    logic [DIV_W-1:0]  div_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        slot, slot_nxt;
    logic              run, step_pending;
    logic              div_wrap, tick, fall, exec_step, scan_wrap;
    logic [1:0]        ch, ch_nxt;
    logic [9:0]        count_nxt;
    logic [11:0]       bcd;
    logic [3:0]        disp_val;
    logic              unused_sw;

    assign rst_n     = pb[0];
    assign unused_sw = ^sw[7:3];

    function automatic logic [11:0] bin2bcd(input logic [9:0] bin);
        logic [11:0] acc;
        logic [9:0]  b;
        acc = '0;
        b   = bin;
        for (int unsigned i = 0; i < 10; i++) begin
            if (acc[3:0]  >= 4'd5) acc[3:0]  = acc[3:0]  + 4'd3;
            if (acc[7:4]  >= 4'd5) acc[7:4]  = acc[7:4]  + 4'd3;
            if (acc[11:8] >= 4'd5) acc[11:8] = acc[11:8] + 4'd3;
            acc = {acc[10:0], b[9]};
            b   = b << 1;
        end
        return acc;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Button edge pulses are registered, giving three cycles from pin to action.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            btn_pulse <= '0;
        end else begin
            sync1     <= pb[3:1];
            sync2     <= sync1;
            sync3     <= sync2;
            btn_pulse <= sync2 & ~sync3;
        end
    end

    assign home_p = btn_pulse[0];
    assign step_p = btn_pulse[1];
    assign run_p  = btn_pulse[2];

    assign div_wrap  = (div_cnt == DIV_W'(ROT_DIV - 1));
    assign tick      = div_wrap & ~rot_clk;
    assign fall      = div_wrap & rot_clk;
    assign exec_step = tick & (run | step_pending) & ~home_p;
    assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Display is driven from next-state values so seg/digit agree with the other outputs.
    always_comb begin
        count_nxt = rot_count;
        ch_nxt    = ch;
        slot_nxt  = slot;
        disp_val  = '0;
        if (home_p)
            count_nxt = '0;
        else if (exec_step)
            count_nxt = (rot_count == 10'(STEPS_REV - 1)) ? '0 : rot_count + 10'd1;
        if (!sw[2])
            ch_nxt = sw[1:0];
        else if (exec_step)
            ch_nxt = ch + 2'd1;
        if (scan_wrap)
            slot_nxt = slot + 2'd1;
        bcd = bin2bcd(count_nxt);
        case (slot_nxt)
            2'd0:    disp_val = bcd[3:0];
            2'd1:    disp_val = bcd[7:4];
            2'd2:    disp_val = bcd[11:8];
            default: disp_val = {2'b00, ch_nxt};
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            rot_clk      <= 1'b0;
            stp_clk      <= 1'b0;
            adc_trg      <= 1'b0;
            rot_count    <= '0;
            run          <= 1'b0;
            step_pending <= 1'b0;
            ch           <= '0;
            rf_sw        <= 4'b0001;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap)
                rot_clk <= ~rot_clk;
            adc_trg <= exec_step;
            if (exec_step)
                stp_clk <= 1'b1;
            else if (fall)
                stp_clk <= 1'b0;
            rot_count <= count_nxt;
            if (home_p)
                run <= 1'b0;
            else if (run_p)
                run <= ~run;
            if (home_p)
                step_pending <= 1'b0;
            else if (exec_step)
                step_pending <= step_p & ~run;
            else if (step_p & ~run)
                step_pending <= 1'b1;
            ch    <= ch_nxt;
            rf_sw <= 4'b0001 << ch_nxt;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            slot     <= '0;
            digit    <= 4'b1110;
            seg      <= 8'hC0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
            slot     <= slot_nxt;
            digit    <= ~(4'b0001 << slot_nxt);
            seg      <= seg7(disp_val);
        end
    end

    assign debug = run;
    assign led   = {rf_sw, run, stp_clk, rot_count[1:0]};

endmodule

// File: tb/tb_cmb_rotator_ctrl.sv
// Self-checking bench for cmb_rotator_ctrl: cycle-level arithmetic reference model
// compared every cycle, plus directed scenarios and randomized button/switch activity.
module tb_cmb_rotator_ctrl;
    localparam int ROT_DIV   = 25;
    localparam int STEPS_REV = 1000;
    localparam int SCAN_DIV  = 16;

    logic       clk50 = 1'b0;
    logic [3:0] pb;
    logic [7:0] sw;
    logic       debug, rot_clk, adc_trg, stp_clk;
    logic [3:0] digit, rf_sw;
    logic [7:0] led, seg;
    logic [9:0] rot_count;

    cmb_rotator_ctrl #(
        .ROT_DIV  (ROT_DIV),
        .STEPS_REV(STEPS_REV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk50    (clk50),
        .pb       (pb),
        .sw       (sw),
        .debug    (debug),
        .rot_clk  (rot_clk),
        .adc_trg  (adc_trg),
        .stp_clk  (stp_clk),
        .digit    (digit),
        .rf_sw    (rf_sw),
        .led      (led),
        .seg      (seg),
        .rot_count(rot_count)
    );

    always #10 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model state: e counts clock edges since reset release.
    int         e, m_count, m_ch, m_slot, m_dv, m_rf;
    bit         m_run, m_pend, m_stp, m_adc, m_tick, m_fall, m_ex, m_req;
    logic [2:0] h [5];
    logic [2:0] m_pulse;
    int         adc_seen = 0;
    int         stp_hi   = 0;

    always @(posedge clk50) begin
        #1;
        if (adc_trg === 1'b1) adc_seen++;
        if (stp_clk === 1'b1) stp_hi++;
        if (pb[0] === 1'b0) begin
            e = 0; m_count = 0; m_ch = 0;
            m_run = 0; m_pend = 0; m_stp = 0; m_adc = 0;
            for (int k = 0; k < 5; k++) h[k] = '0;
            chk("rst_rot_clk", rot_clk, 0);
            chk("rst_stp_clk", stp_clk, 0);
            chk("rst_adc_trg", adc_trg, 0);
            chk("rst_count", rot_count, 0);
            chk("rst_debug", debug, 0);
            chk("rst_rf_sw", rf_sw, 4'b0001);
            chk("rst_led", led, 8'h10);
            chk("rst_digit", digit, 4'b1110);
            chk("rst_seg", seg, 8'hC0);
        end else begin
            e++;
            for (int k = 4; k > 0; k--) h[k] = h[k-1];
            h[0]    = pb[3:1];
            m_pulse = h[3] & ~h[4];
            m_tick  = (e % ROT_DIV == 0) && ((e / ROT_DIV) % 2 == 1);
            m_fall  = (e % ROT_DIV == 0) && ((e / ROT_DIV) % 2 == 0);
            m_ex    = m_tick && (m_run || m_pend) && !m_pulse[0];
            m_req   = m_pulse[1] && !m_run;
            m_adc   = m_ex;
            if (m_ex) m_stp = 1; else if (m_fall) m_stp = 0;
            if (m_pulse[0]) m_count = 0;
            else if (m_ex) m_count = (m_count + 1) % STEPS_REV;
            if (!sw[2]) m_ch = int'(sw[1:0]);
            else if (m_ex) m_ch = (m_ch + 1) % 4;
            if (m_pulse[0]) m_pend = 0;
            else if (m_ex) m_pend = m_req;
            else m_pend = m_pend || m_req;
            if (m_pulse[0]) m_run = 0;
            else if (m_pulse[2]) m_run = !m_run;

            m_slot = (e / SCAN_DIV) % 4;
            case (m_slot)
                0:       m_dv = m_count % 10;
                1:       m_dv = (m_count / 10) % 10;
                2:       m_dv = m_count / 100;
                default: m_dv = m_ch;
            endcase
            m_rf = 1 << m_ch;

            chk("rot_clk", rot_clk, (e / ROT_DIV) % 2);
            chk("stp_clk", stp_clk, m_stp);
            chk("adc_trg", adc_trg, m_adc);
            chk("rot_count", rot_count, m_count);
            chk("debug", debug, m_run);
            chk("rf_sw", rf_sw, m_rf);
            chk("led", led, (m_rf << 4) | (int'(m_run) << 3) | (int'(m_stp) << 2) | (m_count % 4));
            chk("digit", digit, (~(1 << m_slot)) & 4'hF);
            chk("seg", seg, seg_tab[m_dv]);
        end
    end

    task automatic step_cyc(input int n);
        repeat (n) @(posedge clk50);
        #2;
    endtask

    task automatic press(input int b, input int len);
        pb[b] = 1'b1;
        step_cyc(len);
        pb[b] = 1'b0;
    endtask

    task automatic wait_digit(input logic [3:0] pat, input string tag);
        int n;
        n = 0;
        while (digit !== pat && n < 100) begin
            step_cyc(1);
            n++;
        end
        chk(tag, digit, pat);
    endtask

    task automatic wait_model(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (m_count != target && n < budget) begin
            step_cyc(1);
            n++;
        end
        chk(tag, rot_count, target);
    endtask

    logic [3:0] rf_exp [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        pb = 4'b0001;
        sw = 8'h00;
        #5 pb = 4'b0000;
        step_cyc(10);
        pb = 4'b0001;

        step_cyc(1000);
        chk("idle_count", rot_count, 0);
        chk("idle_adc", adc_seen, 0);
        chk("idle_stp", stp_hi, 0);

        press(2, 10);
        step_cyc(150);
        chk("step_adc", adc_seen, 1);
        chk("step_stp_len", stp_hi, ROT_DIV);
        chk("step_count", rot_count, 1);
        wait_digit(4'b1110, "step_slot0");
        chk("step_seg0", seg, 8'hF9);

        press(3, 5);
        step_cyc(245);
        press(3, 5);
        step_cyc(200);
        chk("run_stopped", debug, 0);
        chk("run_count", rot_count, 6);
        chk("run_stp_whole", stp_hi, ROT_DIV * adc_seen);

        press(3, 5);
        wait_model(999, 60000, "wait_999");
        wait_model(0, 200, "wrap_zero");
        wait_digit(4'b1101, "wrap_slot1");
        chk("wrap_tens", seg, 8'hC0);
        wait_digit(4'b1011, "wrap_slot2");
        chk("wrap_hundreds", seg, 8'hC0);

        step_cyc(300);
        pb[1] = 1'b1;
        step_cyc(4);
        chk("home_count", rot_count, 0);
        chk("home_run", debug, 0);
        step_cyc(6);
        pb[1] = 1'b0;
        step_cyc(100);
        chk("home_hold", rot_count, 0);

        sw = 8'h04;
        step_cyc(2);
        for (int i = 0; i < 6; i++) begin
            press(2, 10);
            step_cyc(110);
            chk("rf_auto", rf_sw, rf_exp[i]);
        end
        wait_digit(4'b0111, "rf_slot3");
        chk("rf_slot3_seg", seg, 8'hA4);
        sw = 8'h02;
        step_cyc(2);
        chk("rf_manual", rf_sw, 4'b0100);

        for (int n = 0; n < 800; n++) begin
            pb[3:1] = 3'($urandom_range(0, 7));
            sw      = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                pb[0] = 1'b0;
                step_cyc(int'($urandom_range(1, 5)));
                pb[0] = 1'b1;
            end
            step_cyc(int'($urandom_range(1, 40)));
        end

        pb = 4'b0001;
        sw = 8'h00;
        step_cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
